// File: rtl/wgt_loader_pkg.sv
// Shared definitions for the weight loader: kernel geometry, weight width
// and the FSM state encoding.
package wgt_loader_pkg;

    localparam int KROWS = 3;
    localparam int KCOLS = 3;
    localparam int WGT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_ROW_RDY,
        ST_DONE
    } state_t;

endpackage

// File: rtl/wgt_loader.sv
// Weight loader: streams num_kern 3x3 kernels from weight memory into
// WGT_BUFF one row at a time, holding each complete row until the consumer
// acknowledges it.
module wgt_loader
    import wgt_loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int KCNT_W = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [KCNT_W-1:0]       num_kern,
    input  logic                    abort,
    output logic                    mem_rd_en,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic signed [WGT_W-1:0] mem_rdata,
    output logic signed [WGT_W-1:0] wgt_input,
    output logic                    wgt_read,
    output logic                    row_valid,
    input  logic                    row_ack,
    output logic [1:0]              row_idx,
    output logic [KCNT_W-1:0]       kern_idx,
    output logic                    busy,
    output logic                    done
);

    state_t              state_q;
    state_t              state_d;
    logic [1:0]          col_cnt;
    logic [KCNT_W-1:0]   num_kern_q;
    logic                rd_vld_p1;
    logic                col_last;
    logic                row_last;
    logic                load_last;

    // Memory data arrives one cycle after the read strobe, so the shift
    // enable is simply the strobe delayed by one stage.
    assign wgt_input = mem_rdata;
    assign wgt_read  = rd_vld_p1;

    assign col_last  = (col_cnt == 2'(KCOLS - 1));
    assign row_last  = (row_idx == 2'(KROWS - 1));
    assign load_last = row_last && (kern_idx == num_kern_q - KCNT_W'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control outputs; abort overrides every transition.
    always_comb begin
        state_d   = state_q;
        mem_rd_en = 1'b0;
        row_valid = 1'b0;
        done      = 1'b0;
        busy      = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (num_kern != '0) ? ST_FETCH : ST_DONE;
                end
            end
            ST_FETCH: begin
                mem_rd_en = 1'b1;
                if (col_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d = ST_ROW_RDY;
            end
            ST_ROW_RDY: begin
                row_valid = 1'b1;
                if (row_ack) begin
                    state_d = load_last ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort) begin
            state_d = ST_IDLE;
        end
    end

    // Address, column, row and kernel counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr   <= '0;
            col_cnt    <= '0;
            row_idx    <= '0;
            kern_idx   <= '0;
            num_kern_q <= '0;
        end else if (!abort) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mem_addr   <= base_addr;
                        num_kern_q <= num_kern;
                        col_cnt    <= '0;
                        row_idx    <= '0;
                        kern_idx   <= '0;
                    end
                end
                ST_FETCH: begin
                    // Address keeps running across rows and kernels and
                    // wraps naturally at 2^ADDR_W.
                    mem_addr <= mem_addr + ADDR_W'(1);
                    col_cnt  <= col_last ? 2'd0 : col_cnt + 2'd1;
                end
                ST_ROW_RDY: begin
                    if (row_ack && !load_last) begin
                        if (row_last) begin
                            row_idx  <= '0;
                            kern_idx <= kern_idx + KCNT_W'(1);
                        end else begin
                            row_idx  <= row_idx + 2'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Stage p1: read strobe delayed to line up with returning memory data;
    // abort lets an in-flight pulse through, reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_p1 <= 1'b0;
        end else begin
            rd_vld_p1 <= mem_rd_en;
        end
    end

endmodule

// File: doc/wgt_loader.md
WGT_LOADER -- requirements
Module: wgt_loader

Interface
REQ-001 Parameter ADDR_W, default 10, weight memory address width.
REQ-002 Parameter KCNT_W, default 6, kernel-count width; num_kern values 1..63.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  one-cycle load request; ignored unless in IDLE.
REQ-007 base_addr  input  ADDR_W  first weight address; sampled with start.
REQ-008 num_kern  input  KCNT_W  number of 3x3 kernels to stream; sampled with start.
REQ-009 abort  input  1  synchronous cancel of the current load.
REQ-010 mem_rd_en  output  1  weight memory read strobe.
REQ-011 mem_addr  output  ADDR_W  weight memory read address.
REQ-012 mem_rdata  input  8 signed  memory data, valid exactly 1 cycle after mem_rd_en.
REQ-013 wgt_input  output  8 signed  weight to WGT_BUFF; combinational pass-through of mem_rdata.
REQ-014 wgt_read  output  1  WGT_BUFF shift enable.
REQ-015 row_valid  output  1  all 3 weights of the current kernel row sit in WGT_BUFF.
REQ-016 row_ack  input  1  consumer has used the current row.
REQ-017 row_idx  output  2  current kernel row, 0..2.
REQ-018 kern_idx  output  KCNT_W  current kernel index, 0..num_kern-1.
REQ-019 busy  output  1  high in every state except IDLE.
REQ-020 done  output  1  one-cycle pulse after the final row is acknowledged.

Function
REQ-021 FSM states are IDLE, FETCH, DRAIN, ROW_RDY, DONE.
REQ-022 IDLE->FETCH on start with num_kern!=0; start with num_kern==0 goes IDLE->DONE.
REQ-023 FETCH holds for exactly 3 cycles with mem_rd_en=1 and mem_addr incrementing by 1 each cycle, then goes to DRAIN.
REQ-024 wgt_read equals mem_rd_en delayed by one register stage, so it is high in the 3 cycles following the 3 FETCH cycles' reads (the last in DRAIN).
REQ-025 Push order within a row: w[r][0], w[r][1], w[r][2]; after the row completes, WGT_BUFF holds buf2=w[r][0], buf1=w[r][1], buf0=w[r][2].
REQ-026 DRAIN lasts 1 cycle, then goes to ROW_RDY; row_valid=1 only in ROW_RDY.
REQ-027 In ROW_RDY, row_ack=1: if the row is not the last, go to FETCH next cycle (row_idx+1, or row_idx=0 and kern_idx+1); otherwise go to DONE.
REQ-028 In ROW_RDY, row_ack=0: hold the state, with wgt_read=0 and mem_rd_en=0.
REQ-029 row_ack outside ROW_RDY is ignored.
REQ-030 DONE lasts 1 cycle with done=1, then goes to IDLE.
REQ-031 Addresses are consecutive from base_addr across all rows and kernels, for 9*num_kern reads in total; the address wraps modulo 2^ADDR_W.
REQ-032 Latency with start sampled at edge 0: mem_rd_en is high in cycles 1-3, wgt_read in cycles 2-4, row_valid from cycle 5.
REQ-033 abort=1 in any state forces IDLE next cycle, with mem_rd_en=0, and an in-flight wgt_read is still delivered in the following cycle; abort has priority over start and row_ack.
REQ-034 start while busy has no effect.

Reset
REQ-035 rst=1 forces IDLE, with mem_rd_en, wgt_read, row_valid, busy and done at 0, and mem_addr, row_idx and kern_idx at 0, including any pending wgt_read.
REQ-036 rst has priority over abort, start and row_ack, and takes effect at the next rising edge mid-operation.

Structure
REQ-037 A shared package holds the FSM state enum, KROWS=3, KCOLS=3 and WGT_W=8.
REQ-038 There is no sub-module; a single FSM sits with row, column, kernel and address counters.

Verification
REQ-039 base_addr=0x010, num_kern=1, ack in the cycle row_valid rises -> reads 0x010..0x018, 9 wgt_read pulses, done 1 cycle after the third ack.
REQ-040 Memory[a]=a[7:0]; after row 0 -> buf2=0x10, buf1=0x11, buf0=0x12 when row_valid is high.
REQ-041 row_ack withheld 20 cycles -> row_valid steady, no mem_rd_en or wgt_read, buffers stable.
REQ-042 base_addr=0x3FE, num_kern=1, ADDR_W=10 -> addresses 0x3FE, 0x3FF, 0x000 ... 0x006.
REQ-043 abort during the second FETCH cycle -> IDLE next cycle; exactly 2 wgt_read pulses total; a new start is accepted afterward.
REQ-044 start with num_kern=0 -> no reads, done pulse at cycle 1; start while busy -> ignored, address sequence unchanged.
